// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// quad_step_decoder : synchronised, glitch-filtered quadrature step decoder
// Revision 1.0
// ============================================================================
module quad_step_decoder #(
  parameter int FILT = 3,
  parameter int N    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         clr_err,
  output logic         step,
  output logic         up_down,
  output logic         err,
  output logic [N-1:0] err_cnt
);

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t       state_q;
  logic [1:0]   meta_q;
  logic [1:0]   sync_q;
  logic [1:0]   prev_q;
  logic [1:0]   filt;
  logic [4:0]   warm_q;
  logic         step_q;
  logic         up_q;
  logic         err_q;
  logic [N-1:0] cnt_q;

  logic         step_d;
  logic         up_d;
  logic         illegal_d;
  logic         err_d;
  logic [N-1:0] cnt_d;
  logic [1:0]   delta_d;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [3:0] fc_q;
    logic       f_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        fc_q <= 4'd0;
        f_q  <= 1'b0;
      end else if (state_q == S_INIT) begin
        fc_q <= 4'd0;
        f_q  <= sync_q[g];
      end else if (sync_q[g] != f_q) begin
        if (fc_q == 4'(FILT-1)) begin
          f_q  <= sync_q[g];
          fc_q <= 4'd0;
        end else begin
          fc_q <= fc_q + 4'd1;
        end
      end else begin
        fc_q <= 4'd0;
      end
    end

    assign filt[g] = f_q;
  end

  // Position on the Gray cycle 00->01->11->10; +1 is up, +3 is down, +2 illegal.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  always_comb begin
    delta_d   = gray_pos(filt) - gray_pos(prev_q);
    step_d    = 1'b0;
    up_d      = up_q;
    illegal_d = 1'b0;
    if (state_q == S_TRACK) begin
      case (delta_d)
        2'd1: begin
          step_d = 1'b1;
          up_d   = 1'b1;
        end
        2'd3: begin
          step_d = 1'b1;
          up_d   = 1'b0;
        end
        2'd2:    illegal_d = 1'b1;
        default: ;
      endcase
    end

    err_d = err_q;
    cnt_d = cnt_q;
    if (illegal_d) begin
      err_d = 1'b1;
      if (clr_err) begin
        cnt_d = N'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + N'(1);
      end
    end else if (clr_err) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      meta_q  <= 2'b00;
      sync_q  <= 2'b00;
      prev_q  <= 2'b00;
      warm_q  <= 5'd0;
      step_q  <= 1'b0;
      up_q    <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= {a_in, b_in};
      sync_q <= meta_q;
      step_q <= step_d;
      up_q   <= up_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      case (state_q)
        S_INIT: begin
          prev_q <= sync_q;
          warm_q <= warm_q + 5'd1;
          if (warm_q == 5'(FILT+1)) begin
            state_q <= S_TRACK;
          end
        end
        S_TRACK: prev_q  <= filt;
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign step    = step_q;
  assign up_down = up_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
`default_nettype wire
